// File: rtl/sprite_pkg.sv
// Shared sprite definitions: geometry, in_entity field layout, sprite IDs,
// the 16-entry RGB222 palette and the 8x8 bitmaps (row 0 first, column 0 = MSB).
package sprite_pkg;

   localparam int SPR_TILE_SIZE = 8;
   localparam int SPR_UPSCALE   = 5;
   localparam int SPR_COORD_W   = 3;
   localparam int H_W           = 10;
   localparam int COLOUR_W      = 6;

   localparam int ENT_ROW_MSB = 8;
   localparam int ENT_ROW_LSB = 6;
   localparam int ENT_ID_MSB  = 5;
   localparam int ENT_ID_LSB  = 2;
   localparam int ENT_ORI_MSB = 1;
   localparam int ENT_ORI_LSB = 0;

   typedef enum logic [1:0] {
      ORI_R0   = 2'b00,
      ORI_R90  = 2'b01,
      ORI_R180 = 2'b10,
      ORI_R270 = 2'b11
   } orient_e;

   typedef enum logic [3:0] {
      ID_SHIP    = 4'h0,
      ID_ALIEN_A = 4'h1,
      ID_ALIEN_B = 4'h2,
      ID_ALIEN_C = 4'h3,
      ID_BULLET  = 4'h4,
      ID_BOMB    = 4'h5,
      ID_SHIELD  = 4'h6,
      ID_UFO     = 4'h7,
      ID_EXPLODE = 4'h8,
      ID_DIGIT_0 = 4'h9,
      ID_DIGIT_1 = 4'hA,
      ID_DIGIT_2 = 4'hB,
      ID_DIGIT_3 = 4'hC,
      ID_DIGIT_4 = 4'hD,
      ID_FRAME   = 4'hE,
      ID_NONE    = 4'hF
   } sprite_id_e;

   typedef enum logic {
      ST_UNSYNCED = 1'b0,
      ST_SYNCED   = 1'b1
   } sync_state_e;

   // Index [0] is the top row; within a row, bit 7 is column 0.
   typedef logic [0:7][7:0] sprite_bitmap_t;

   function automatic logic [COLOUR_W-1:0] sprite_palette(input logic [3:0] id);
      case (id)
         ID_SHIP:    return 6'h0C;
         ID_ALIEN_A: return 6'h30;
         ID_ALIEN_B: return 6'h3C;
         ID_ALIEN_C: return 6'h33;
         ID_BULLET:  return 6'h3F;
         ID_BOMB:    return 6'h38;
         ID_SHIELD:  return 6'h08;
         ID_UFO:     return 6'h23;
         ID_EXPLODE: return 6'h3E;
         ID_FRAME:   return 6'h07;
         ID_NONE:    return 6'h00;
         default:    return 6'h2A;
      endcase
   endfunction

   function automatic sprite_bitmap_t sprite_bitmap(input logic [3:0] id);
      case (id)
         ID_SHIP:    return 64'h1818_3C7E_FFFF_6642;
         ID_ALIEN_A: return 64'hB241_E418_9C27_00CA;
         ID_ALIEN_B: return 64'h3C7E_DBFF_6624_4281;
         ID_ALIEN_C: return 64'h2466_FFDB_FF7E_2442;
         ID_BULLET:  return 64'h1818_1818_1818_0000;
         ID_BOMB:    return 64'h0018_3C7E_7E3C_1800;
         ID_SHIELD:  return 64'h7EFF_FFFF_E7C3_8100;
         ID_UFO:     return 64'h003C_7EDB_FF66_0000;
         ID_EXPLODE: return 64'h9142_2418_1824_4289;
         ID_DIGIT_0: return 64'h3C66_6E76_6666_3C00;
         ID_DIGIT_1: return 64'h1838_1818_1818_7E00;
         ID_DIGIT_2: return 64'h3C66_060C_3060_7E00;
         ID_DIGIT_3: return 64'h3C66_061C_0666_3C00;
         ID_DIGIT_4: return 64'h0C1C_3C6C_7E0C_0C00;
         ID_FRAME:   return 64'hFF81_8181_8181_81FF;
         default:    return 64'h0;
      endcase
   endfunction

endpackage

// File: rtl/sprite_rom.sv
// Combinational sprite bitmap lookup: (ID, bitmap row, bitmap column) -> 1 pixel bit.
module sprite_rom
   import sprite_pkg::*;
(
   input  logic [3:0]             i_id,
   input  logic [SPR_COORD_W-1:0] i_row,
   input  logic [SPR_COORD_W-1:0] i_col,
   output logic                   o_bit
);

   sprite_bitmap_t w_bitmap;

   always_comb begin
      w_bitmap = sprite_bitmap(i_id);
      o_bit    = w_bitmap[i_row][3'd7 - i_col];
   end

endmodule

// File: rtl/sprite_pixel_renderer.sv
// Two-stage sprite pixel renderer: aligns the scan counter with in_entity, tracks the
// sprite column without a divider and looks up the palette colour. Orientation: SPRITE_ROTATION_EN.
module sprite_pixel_renderer
   import sprite_pkg::*;
#(
   parameter int                  UPSCALE_FACTOR = SPR_UPSCALE,
   parameter int                  TILE_SIZE      = SPR_TILE_SIZE,
   parameter logic [COLOUR_W-1:0] BG_COLOUR      = 6'h00
)(
   input  logic                clk,
   input  logic                reset,
   input  logic [8:0]          in_entity,
   input  logic [H_W-1:0]      counter_H,
   input  logic [H_W-1:0]      counter_V,
   input  logic                video_active,
   output logic [COLOUR_W-1:0] pixel_colour,
   output logic                pixel_valid
);

   localparam int SUB_W = (UPSCALE_FACTOR > 1) ? $clog2(UPSCALE_FACTOR) : 1;
   localparam logic [SUB_W-1:0]       SUB_LAST = SUB_W'(UPSCALE_FACTOR - 1);
   localparam logic [SPR_COORD_W-1:0] COL_LAST = SPR_COORD_W'(TILE_SIZE - 1);

   logic [H_W-1:0]         r_h_d1;
   logic                   r_va_d1;
   logic                   r_d1_vld;
   logic [SUB_W-1:0]       r_sub_cnt;
   logic [SPR_COORD_W-1:0] r_col_cnt;
   sync_state_e            r_state;
   logic [COLOUR_W-1:0]    r_colour;
   logic                   r_valid;

   logic                   w_line_start;
   logic                   w_synced;
   sync_state_e            w_state_next;
   logic [SUB_W-1:0]       w_sub_cur;
   logic [SUB_W-1:0]       w_sub_next;
   logic [SPR_COORD_W-1:0] w_col_cur;
   logic [SPR_COORD_W-1:0] w_col_next;
   logic [SPR_COORD_W-1:0] w_row;
   logic [3:0]             w_id;
   logic [SPR_COORD_W-1:0] w_bm_row;
   logic [SPR_COORD_W-1:0] w_bm_col;
   logic                   w_bit;
   logic [COLOUR_W-1:0]    w_colour;
   logic                   w_unused_inputs;

   assign w_row = in_entity[ENT_ROW_MSB:ENT_ROW_LSB];
   assign w_id  = in_entity[ENT_ID_MSB:ENT_ID_LSB];

   // r_d1_vld keeps the reset value of r_h_d1 from being mistaken for a line start.
   assign w_line_start = r_d1_vld && (r_h_d1 == '0);
   assign w_synced     = (r_state == ST_SYNCED) || w_line_start;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_h_d1   <= '0;
         r_va_d1  <= 1'b0;
         r_d1_vld <= 1'b0;
      end else begin
         r_h_d1   <= counter_H;
         r_va_d1  <= video_active;
         r_d1_vld <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ST_UNSYNCED;
      else        r_state <= w_state_next;
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_state_next = r_state;
      if (w_line_start) w_state_next = ST_SYNCED;
   end

   // Counters hold the sub-pixel/column of the pixel currently in stage 1.
   always_comb begin
      w_sub_cur  = w_line_start ? '0 : r_sub_cnt;
      w_col_cur  = w_line_start ? '0 : r_col_cnt;
      w_sub_next = w_sub_cur + 1'b1;
      w_col_next = w_col_cur;
      if (w_sub_cur == SUB_LAST) begin
         w_sub_next = '0;
         w_col_next = (w_col_cur == COL_LAST) ? '0 : w_col_cur + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sub_cnt <= '0;
         r_col_cnt <= '0;
      end else begin
         r_sub_cnt <= w_sub_next;
         r_col_cnt <= w_col_next;
      end
   end

`ifdef SPRITE_ROTATION_EN
   orient_e w_orient;
   assign w_orient        = orient_e'(in_entity[ENT_ORI_MSB:ENT_ORI_LSB]);
   assign w_unused_inputs = ^counter_V;

   always_comb begin
      w_bm_row = w_row;
      w_bm_col = w_col_cur;
      case (w_orient)
         ORI_R90: begin
            w_bm_row = 3'd7 - w_col_cur;
            w_bm_col = w_row;
         end
         ORI_R180: begin
            w_bm_row = 3'd7 - w_row;
            w_bm_col = 3'd7 - w_col_cur;
         end
         ORI_R270: begin
            w_bm_row = w_col_cur;
            w_bm_col = 3'd7 - w_row;
         end
         default: ;
      endcase
   end
`else
   assign w_unused_inputs = ^{counter_V, in_entity[ENT_ORI_MSB:ENT_ORI_LSB]};
   assign w_bm_row        = w_row;
   assign w_bm_col        = w_col_cur;
`endif

   sprite_rom u_rom (
      .i_id  (w_id),
      .i_row (w_bm_row),
      .i_col (w_bm_col),
      .o_bit (w_bit)
   );

   // Blanking wins over everything; unsynced or empty pixels show the background.
   always_comb begin
      w_colour = BG_COLOUR;
      if (!r_va_d1)
         w_colour = '0;
      else if (w_synced && (w_id != ID_NONE) && w_bit)
         w_colour = sprite_palette(w_id);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_colour <= '0;
         r_valid  <= 1'b0;
      end else begin
         r_colour <= w_colour;
         r_valid  <= r_va_d1;
      end
   end

   assign pixel_colour = r_colour;
   assign pixel_valid  = r_valid;

endmodule

// File: tb/tb_sprite_pixel_renderer.sv
// Directed bench for sprite_pixel_renderer: sync, column stepping, orientation,
// empty ID, blanking, line wrap and mid-line reset against hand-derived bitmap rows.
module tb_sprite_pixel_renderer;

   localparam logic [5:0] TB_BG   = 6'h15;
   localparam logic [5:0] PAL_ID1 = 6'h30;
   localparam int M_BG   = 0;
   localparam int M_PAT  = 1;
   localparam int M_ZERO = 2;

   // ID 1, row 0 read along columns 0..7 (MSB = column 0)
   localparam logic [7:0] PAT_00 = 8'b1011_0010;
`ifdef SPRITE_ROTATION_EN
   localparam logic [7:0] PAT_10 = 8'b0101_0011;
   localparam logic [7:0] PAT_01 = 8'b1001_0101;
`else
   localparam logic [7:0] PAT_10 = PAT_00;
   localparam logic [7:0] PAT_01 = PAT_00;
`endif

   localparam logic [8:0] ENT_00 = {3'd0, 4'd1, 2'b00};
   localparam logic [8:0] ENT_01 = {3'd0, 4'd1, 2'b01};
   localparam logic [8:0] ENT_10 = {3'd0, 4'd1, 2'b10};

   logic       clk = 1'b0;
   logic       reset;
   logic [8:0] in_entity;
   logic [9:0] counter_H;
   logic [9:0] counter_V;
   logic       video_active;
   logic [5:0] pixel_colour;
   logic       pixel_valid;

   int n_checks = 0;
   int n_pass   = 0;

   sprite_pixel_renderer #(
      .UPSCALE_FACTOR (5),
      .TILE_SIZE      (8),
      .BG_COLOUR      (TB_BG)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .in_entity    (in_entity),
      .counter_H    (counter_H),
      .counter_V    (counter_V),
      .video_active (video_active),
      .pixel_colour (pixel_colour),
      .pixel_valid  (pixel_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick(input int h, input logic va, input logic [8:0] ent);
      @(negedge clk);
      counter_H    = 10'(h);
      video_active = va;
      in_entity    = ent;
   endtask

   function automatic logic [5:0] exp_colour(input int h, input int mode, input logic [7:0] pat);
      int col;
      col = (h / 5) % 8;
      case (mode)
         M_ZERO:  return 6'h00;
         M_PAT:   return pat[7 - col] ? PAL_ID1 : TB_BG;
         default: return TB_BG;
      endcase
   endfunction

   // Drives n consecutive pixels from h0 (plus two drain pixels) and checks each
   // output two clocks after its counter_H value was presented.
   task automatic scan(input string tag, input int h0, input int n, input logic [8:0] ent,
                       input logic va, input int mode, input logic [7:0] pat);
      for (int i = 0; i < n + 2; i++) begin
         tick((h0 + i) % 640, va, ent);
         if (i >= 2) begin
            int hc;
            hc = (h0 + i - 2) % 640;
            check($sformatf("%s colour h=%0d", tag, hc), 32'(pixel_colour), 32'(exp_colour(hc, mode, pat)));
            check($sformatf("%s valid h=%0d", tag, hc), 32'(pixel_valid), 32'(va));
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      reset        = 1'b0;
      counter_H    = 10'd600;
      counter_V    = 10'd0;
      video_active = 1'b0;
      in_entity    = ENT_00;
      repeat (3) @(negedge clk);
      check("reset colour", 32'(pixel_colour), 32'h00);
      check("reset valid", 32'(pixel_valid), 32'h0);
      reset = 1'b1;

      // Not yet synced: background even though the entity bits are lit
      scan("unsynced", 630, 10, ENT_00, 1'b1, M_BG, 8'h00);
      scan("orient00", 0, 40, ENT_00, 1'b1, M_PAT, PAT_00);

      // Tile boundary: counters seen while stage 1 holds counter_H 39 and 40
      for (int h = 0; h < 40; h++) tick(h, 1'b1, ENT_00);
      tick(40, 1'b1, ENT_00);
      check("stage1 h at 39", 32'(dut.r_h_d1), 32'd39);
      check("sub at h=39", 32'(dut.r_sub_cnt), 32'd4);
      check("col at h=39", 32'(dut.r_col_cnt), 32'd7);
      tick(41, 1'b1, ENT_00);
      check("sub at h=40", 32'(dut.r_sub_cnt), 32'd0);
      check("col at h=40", 32'(dut.r_col_cnt), 32'd0);

      scan("orient10", 0, 40, ENT_10, 1'b1, M_PAT, PAT_10);
      scan("orient01", 0, 40, ENT_01, 1'b1, M_PAT, PAT_01);
      scan("id_none", 0, 640, 9'h1FF, 1'b1, M_BG, 8'h00);
      scan("blank", 0, 10, ENT_00, 1'b0, M_ZERO, PAT_00);
      scan("wrap", 0, 650, ENT_00, 1'b1, M_PAT, PAT_00);

      // Mid-line reset: output must clear without waiting for a clock edge
      scan("pre_reset", 0, 3, ENT_00, 1'b1, M_PAT, PAT_00);
      check("lit before reset", 32'(pixel_colour), 32'(PAL_ID1));
      reset = 1'b0;
      #1;
      check("async reset colour", 32'(pixel_colour), 32'h00);
      check("async reset valid", 32'(pixel_valid), 32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      scan("post_reset", 20, 20, ENT_00, 1'b1, M_BG, 8'h00);
      scan("resync", 0, 10, ENT_00, 1'b1, M_PAT, PAT_00);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
